// File: rtl/toggle_pkg.sv
// Shared types and sizing helpers for the toggle burst sequencer.
package toggle_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_t;

  localparam int DEF_TIME_W = 16;
  localparam int DEF_CNT_W  = 16;

  // A 1 MHz clock still needs a 1-bit counter to keep port widths legal.
  function automatic int presc_w(input int freq_mhz);
    return (freq_mhz > 1) ? $clog2(freq_mhz) : 1;
  endfunction

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond prescaler: counts 0..CLK_FREQ_MHz-1 while enabled, strobes tick on terminal count.
module us_tick_gen
  import toggle_pkg::*;
#(
  parameter int CLK_FREQ_MHz = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int W = presc_w(CLK_FREQ_MHz);
  localparam logic [W-1:0] TERM = W'(CLK_FREQ_MHz - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == TERM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/toggle_burst_ctrl.sv
// Start/abort burst engine: emits pulse_count pulses (0 = continuous) of programmable on/off time.
// All outputs registered; config latched only on the accepting start edge.
module toggle_burst_ctrl
  import toggle_pkg::*;
#(
  parameter int CLK_FREQ_MHz = 100,
  parameter int TIME_W       = DEF_TIME_W,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [TIME_W-1:0] ton_us,
  input  logic [TIME_W-1:0] toff_us,
  input  logic [CNT_W-1:0]  pulse_count,
  output logic              pulse_out,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  pulse_idx
);

  state_t              state_q, state_d;
  logic [TIME_W-1:0]   ton_q, ton_d, toff_q, toff_d, phase_q, phase_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, idx_q, idx_d;
  logic                pulse_q, pulse_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic                us_tick, phase_end;

  us_tick_gen #(.CLK_FREQ_MHz(CLK_FREQ_MHz)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  ((state_q == IDLE) || phase_end),
    .en   (state_q != IDLE),
    .tick (us_tick)
  );

  always_comb begin
    state_d   = state_q;
    ton_d     = ton_q;
    toff_d    = toff_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
    idx_d     = idx_q;
    pulse_d   = pulse_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    phase_end = 1'b0;
    case (state_q)
      IDLE: begin
        // abort has priority: a simultaneous start is dropped silently.
        if (start && !abort) begin
          if (ton_us != '0 && toff_us != '0) begin
            ton_d   = ton_us;
            toff_d  = toff_us;
            cnt_d   = pulse_count;
            idx_d   = '0;
            phase_d = '0;
            state_d = ON;
            pulse_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ON: begin
        if (abort) begin
          state_d = IDLE;
          pulse_d = 1'b0;
          busy_d  = 1'b0;
          phase_d = '0;
        end else if (us_tick) begin
          if (phase_q == ton_q - TIME_W'(1)) begin
            phase_end = 1'b1;
            phase_d   = '0;
            state_d   = OFF;
            pulse_d   = 1'b0;
            idx_d     = idx_q + CNT_W'(1);
          end else begin
            phase_d = phase_q + TIME_W'(1);
          end
        end
      end
      OFF: begin
        if (abort) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          phase_d = '0;
        end else if (us_tick) begin
          if (phase_q == toff_q - TIME_W'(1)) begin
            phase_end = 1'b1;
            phase_d   = '0;
            if (cnt_q != '0 && idx_q == cnt_q) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = ON;
              pulse_d = 1'b1;
            end
          end else begin
            phase_d = phase_q + TIME_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        pulse_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ton_q   <= '0;
      toff_q  <= '0;
      cnt_q   <= '0;
      phase_q <= '0;
      idx_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ton_q   <= ton_d;
      toff_q  <= toff_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign pulse_out = pulse_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign pulse_idx = idx_q;

endmodule

// File: tb/tb_toggle_burst_ctrl.sv
// Directed bench for toggle_burst_ctrl: single-cycle vector table plus cycle-exact burst traces.
module tb_toggle_burst_ctrl;

  localparam int F  = 100;
  localparam int TW = 16;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [TW-1:0] ton_us, toff_us;
  logic [CW-1:0] pulse_count;
  logic          pulse_out, busy, done, err;
  logic [CW-1:0] pulse_idx;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  toggle_burst_ctrl #(.CLK_FREQ_MHz(F), .TIME_W(TW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .ton_us      (ton_us),
    .toff_us     (toff_us),
    .pulse_count (pulse_count),
    .pulse_out   (pulse_out),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .pulse_idx   (pulse_idx)
  );

  typedef struct {
    logic          rst;
    logic          start;
    logic          abort;
    logic [TW-1:0] ton;
    logic [TW-1:0] toff;
    logic [CW-1:0] cnt;
    logic [3:0]    exp_flags;  // {pulse_out, busy, done, err}
    logic [CW-1:0] exp_idx;
    string         name;
  } vec_t;

  vec_t vecs[9];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_burst(input int ton, input int toff, input int cnt);
    ton_us      = TW'(ton);
    toff_us     = TW'(toff);
    pulse_count = CW'(cnt);
    start       = 1'b1;
    tick();
    start       = 1'b0;
    ton_us      = TW'($urandom);
    toff_us     = TW'($urandom);
    pulse_count = CW'($urandom);
  endtask

  // Checks every cycle c0..c1 (cycle 1 = first cycle after the accepting edge)
  // against the ideal waveform; optionally pokes a bogus start at cycle 'poke'.
  task automatic trace(input string name, input int c0, input int c1, input int ton,
                       input int toff, input int cnt, input int poke);
    int bad, first, p, num, pos, ei;
    logic ep, eb, ed, fin;
    bad   = 0;
    first = -1;
    p     = (ton + toff) * F;
    for (int c = c0; c <= c1; c++) begin
      if (c != c0) tick();
      num = (c - 1) / p;
      pos = (c - 1) % p;
      fin = (cnt != 0) && (c > cnt * p);
      ep  = !fin && (pos < ton * F);
      eb  = !fin;
      ed  = (cnt != 0) && (c == cnt * p + 1);
      ei  = fin ? cnt : num + ((pos >= ton * F) ? 1 : 0);
      ei  = ei & ((1 << CW) - 1);
      if ({pulse_out, busy, done, err} !== {ep, eb, ed, 1'b0} || pulse_idx !== ei[CW-1:0]) begin
        bad++;
        if (first < 0) first = c;
      end
      start = (c == poke);
      if (c == poke) ton_us = TW'(7);
    end
    start = 1'b0;
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s: %0d mismatching cycles (first at cycle %0d), expected 0", name, bad, first);
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    ton_us = '0; toff_us = '0; pulse_count = '0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 4'd0, 4'b0000, 4'd0, "reset"};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 16'd3, 16'd3, 4'd2, 4'b0000, 4'd0, "idle"};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 16'd0, 16'd5, 4'd2, 4'b0001, 4'd0, "rej_ton0"};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 16'd0, 16'd5, 4'd2, 4'b0000, 4'd0, "rej_ton0_after"};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 16'd5, 16'd0, 4'd2, 4'b0001, 4'd0, "rej_toff0"};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 16'd5, 16'd0, 4'd2, 4'b0000, 4'd0, "rej_toff0_after"};
    vecs[6] = '{1'b0, 1'b1, 1'b1, 16'd1, 16'd1, 4'd1, 4'b0000, 4'd0, "start_abort_idle"};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 16'd1, 16'd1, 4'd1, 4'b0000, 4'd0, "abort_idle"};
    vecs[8] = '{1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 4'd1, 4'b0001, 4'd0, "rej_both0"};

    foreach (vecs[i]) begin
      rst         = vecs[i].rst;
      start       = vecs[i].start;
      abort       = vecs[i].abort;
      ton_us      = vecs[i].ton;
      toff_us     = vecs[i].toff;
      pulse_count = vecs[i].cnt;
      tick();
      chk({vecs[i].name, "_flags"}, {28'd0, pulse_out, busy, done, err}, {28'd0, vecs[i].exp_flags});
      chk({vecs[i].name, "_idx"}, {28'd0, pulse_idx}, {28'd0, vecs[i].exp_idx});
    end
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    tick();

    // Finite burst, then a start on the done cycle, then a start during ON.
    start_burst(1, 2, 3);
    trace("finite_burst", 1, 901, 1, 2, 3, 0);
    chk("finite_done", {31'd0, done}, 32'd1);
    chk("finite_idx", {28'd0, pulse_idx}, 32'd3);
    start_burst(1, 1, 1);
    chk("restart_on_done_pulse", {31'd0, pulse_out}, 32'd1);
    chk("restart_on_done_idx", {28'd0, pulse_idx}, 32'd0);
    trace("start_during_on", 1, 201, 1, 1, 1, 50);
    tick();
    chk("done_one_cycle", {30'd0, done, busy}, 32'd0);

    // Continuous mode, abort 50 cycles into the 6th ON phase.
    start_burst(1, 1, 0);
    trace("continuous", 1, 1050, 1, 1, 0, 0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_flags", {28'd0, pulse_out, busy, done, err}, 32'd0);
    chk("abort_idx", {28'd0, pulse_idx}, 32'd5);
    tick();
    chk("abort_quiet", {28'd0, pulse_out, busy, done, err}, 32'd0);

    // Reset during OFF of pulse 2, then a fresh burst.
    start_burst(1, 1, 3);
    trace("pre_reset", 1, 350, 1, 1, 3, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("reset_mid_flags", {28'd0, pulse_out, busy, done, err}, 32'd0);
    chk("reset_mid_idx", {28'd0, pulse_idx}, 32'd0);
    start_burst(2, 1, 1);
    trace("after_reset", 1, 301, 2, 1, 1, 0);

    // Index wrap with a 4-bit counter in continuous mode.
    tick();
    start_burst(1, 1, 0);
    trace("wrap_a", 1, 3001, 1, 1, 0, 0);
    chk("wrap_idx15", {28'd0, pulse_idx}, 32'd15);
    tick();
    trace("wrap_b", 3002, 3101, 1, 1, 0, 0);
    chk("wrap_idx0", {28'd0, pulse_idx}, 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("wrap_abort", {28'd0, pulse_out, busy, done, err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/toggle_burst_ctrl.md
Name: toggle_burst_ctrl

Overview:
Run-time programmable sequencer for the board's square-wave/strobe outputs. It replaces fixed compile-time on/off timing with a start/abort-controlled burst engine. On each accepted start it latches on-time, off-time (in microseconds) and pulse count. It then emits that many pulses, or runs continuously, and reports busy/done/error to the PS-side control logic.

Parameters:
CLK_FREQ_MHz, 100, clock frequency in MHz; cycles per microsecond; must be >= 1.
TIME_W, 16, width of ton_us/toff_us config fields.
CNT_W, 16, width of pulse count and pulse index.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous, active-high reset.
start  in  1  request to begin a burst; sampled every cycle.
abort  in  1  stop the running burst immediately.
ton_us  in  TIME_W  high time per pulse, in us.
toff_us  in  TIME_W  low time per pulse, in us.
pulse_count  in  CNT_W  pulses per burst; 0 = continuous until abort.
pulse_out  out  1  generated pulse train, registered.
busy  out  1  high while in ON or OFF.
done  out  1  one-cycle strobe when a finite burst completes normally.
err  out  1  one-cycle strobe when a start is rejected.
pulse_idx  out  CNT_W  number of completed ON phases in the current/last burst.

Behaviour:
- Reset (sync, rst=1 at an edge): state=IDLE; pulse_out=0, busy=0, done=0, err=0, pulse_idx=0; prescaler and phase counters=0. Applies mid-burst; no done is generated.
- States: IDLE, ON, OFF. All outputs are registered.
- IDLE, start=1, abort=0, ton_us!=0 and toff_us!=0 at edge k:
  - Latch ton_us, toff_us, pulse_count; clear pulse_idx and the prescaler.
  - Go to ON; pulse_out=1 and busy=1 from cycle k+1.
- IDLE, start=1 with ton_us==0 or toff_us==0: err=1 for cycle k+1; stay IDLE; latched config unchanged.
- start while busy: ignored, with no err. Config inputs are don't-care outside the accepting cycle.
- Prescaler: counts 0..CLK_FREQ_MHz-1 and emits us_tick on the terminal count. It runs only in ON/OFF and restarts at 0 on every phase entry.
- ON: phase us-counter increments per us_tick.
  - After ton_us ticks, ON lasts exactly ton_us*CLK_FREQ_MHz cycles.
  - Then go to OFF with pulse_out=0, and pulse_idx increments in the same transition.
- OFF lasts exactly toff_us*CLK_FREQ_MHz cycles. At its end:
  - If pulse_count!=0 and pulse_idx==pulse_count: go to IDLE; busy=0 and done=1 in the same cycle.
  - Otherwise go to ON.
- Pulse period = (ton_us+toff_us)*CLK_FREQ_MHz cycles. A start at edge k with N pulses gives done=1 on cycle k+1+N*period. A new start is accepted on that same edge.
- Continuous mode (pulse_count=0): never done; pulse_idx wraps 2^CNT_W-1 -> 0 without side effects.
- abort=1 in ON/OFF: next cycle IDLE, pulse_out=0, busy=0, done=0; pulse_idx holds its value.
- abort in IDLE: no effect. start and abort together in IDLE: abort wins; start is ignored and err is not raised.
- No combinational input-to-output paths. Counter widths: prescaler clog2(CLK_FREQ_MHz), phase counter TIME_W.

Decomposition:
- Package toggle_pkg holds:
  - the state encoding (IDLE=2'd0, ON=2'd1, OFF=2'd2);
  - TIME_W/CNT_W defaults;
  - a helper function for prescaler width (clog2).
- One sub-module, us_tick_gen: parameter CLK_FREQ_MHz; ports clk, rst, clr, en, tick. It contains the prescaler only. The FSM, phase counter and pulse index stay in toggle_burst_ctrl.

Test Plan:
- Finite burst: CLK_FREQ_MHz=100, ton=1, toff=2, count=3, start at edge k.
  - pulse_out high at k+1..k+100, k+301..k+400 and k+601..k+700.
  - done=1 only at k+901; busy falls at k+901; pulse_idx=3.
- Rejected config: ton=0, toff=5, start=1 -> err=1 for exactly one cycle, busy stays 0, pulse_out stays 0. Repeat with toff=0 for the same result.
- Continuous mode plus abort: count=0, ton=toff=1.
  - 5 full periods of 200 cycles each observed.
  - abort at cycle 50 of the 6th ON -> next cycle pulse_out=0, busy=0, no done, pulse_idx=5.
- Start collisions:
  - start during ON is ignored; period and count are unaffected.
  - start+abort together in IDLE -> nothing happens.
  - start on the done cycle is accepted, and pulse_out rises the next cycle.
- Reset mid-operation: rst=1 during OFF of pulse 2 -> next cycle all outputs 0. A following start restarts with pulse_idx from 0 and full ON width.
- Wrap: CNT_W=4, count=0, ton=toff=1 -> pulse_idx reaches 15 then 0, and pulse_out timing stays unchanged.
